// File: rtl/axi_4lite_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction out, one result back.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN to abort stalled transactions after TIMEOUT_CYCLES.
module axi_4lite_master #(
  parameter int AXI_Dwidth     = 32,
  parameter int AXI_Addrwidth  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       AXI_aclk,
  input  logic                       AXI_aresetn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AXI_Addrwidth-1:0]   cmd_addr,
  input  logic [AXI_Dwidth-1:0]      cmd_wdata,
  input  logic [AXI_Dwidth/8-1:0]    cmd_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [AXI_Dwidth-1:0]      rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic [AXI_Addrwidth-1:0]   AXI_awaddr,
  output logic                       AXI_awvalid,
  input  logic                       AXI_awready,
  output logic [AXI_Dwidth-1:0]      AXI_wdata,
  output logic [AXI_Dwidth/8-1:0]    AXI_wstrb,
  output logic                       AXI_wvalid,
  input  logic                       AXI_wready,
  input  logic [1:0]                 AXI_bresp,
  input  logic                       AXI_bvalid,
  output logic                       AXI_bready,
  output logic [AXI_Addrwidth-1:0]   AXI_areadaddr,
  output logic [2:0]                 AXI_arprotect,
  output logic                       AXI_arvalid,
  input  logic                       AXI_arready,
  input  logic [AXI_Dwidth-1:0]      AXI_rdata,
  input  logic [1:0]                 AXI_rresp,
  input  logic                       AXI_rvalid,
  output logic                       AXI_rready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state_r;
  logic   aw_done_r, w_done_r;
  logic   aw_done_s, w_done_s, leave_s;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] timer_r;
  logic          busy_s;
  assign busy_s = (state_r == WR_REQ) || (state_r == WR_RESP) ||
                  (state_r == RD_REQ) || (state_r == RD_RESP);
`endif

  assign AXI_arprotect = 3'b000;

  // Handshake bookkeeping and the exit condition of each busy state
  always_comb begin
    aw_done_s = aw_done_r | (AXI_awvalid & AXI_awready);
    w_done_s  = w_done_r  | (AXI_wvalid  & AXI_wready);
    case (state_r)
      WR_REQ:  leave_s = aw_done_s & w_done_s;
      WR_RESP: leave_s = AXI_bready & AXI_bvalid;
      RD_REQ:  leave_s = AXI_arvalid & AXI_arready;
      RD_RESP: leave_s = AXI_rready & AXI_rvalid;
      default: leave_s = 1'b0;
    endcase
  end

  // Transaction FSM with registered command, AXI and response outputs
  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_r       <= IDLE;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      AXI_awaddr    <= '0;
      AXI_awvalid   <= 1'b0;
      AXI_wdata     <= '0;
      AXI_wstrb     <= '0;
      AXI_wvalid    <= 1'b0;
      AXI_bready    <= 1'b0;
      AXI_areadaddr <= '0;
      AXI_arvalid   <= 1'b0;
      AXI_rready    <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
      timer_r       <= '0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              AXI_awaddr  <= cmd_addr;
              AXI_wdata   <= cmd_wdata;
              AXI_wstrb   <= cmd_wstrb;
              AXI_awvalid <= 1'b1;
              AXI_wvalid  <= 1'b1;
              state_r     <= WR_REQ;
            end else begin
              AXI_areadaddr <= cmd_addr;
              AXI_arvalid   <= 1'b1;
              state_r       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (AXI_awvalid && AXI_awready) AXI_awvalid <= 1'b0;
          if (AXI_wvalid && AXI_wready)   AXI_wvalid  <= 1'b0;
          if (leave_s) begin
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            AXI_bready <= 1'b1;
            state_r    <= WR_RESP;
          end else begin
            aw_done_r <= aw_done_s;
            w_done_r  <= w_done_s;
          end
        end
        WR_RESP: begin
          if (leave_s) begin
            AXI_bready <= 1'b0;
            rsp_resp   <= AXI_bresp;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            state_r    <= DONE;
          end
        end
        RD_REQ: begin
          if (leave_s) begin
            AXI_arvalid <= 1'b0;
            AXI_rready  <= 1'b1;
            state_r     <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (leave_s) begin
            AXI_rready <= 1'b0;
            rsp_rdata  <= AXI_rdata;
            rsp_resp   <= AXI_rresp;
            rsp_valid  <= 1'b1;
            state_r    <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
`ifdef AXI_MASTER_TIMEOUT_EN
      // Watchdog abort overrides whatever the busy state decided this cycle
      if (busy_s && (timer_r == TO_LIM)) begin
        timer_r     <= '0;
        aw_done_r   <= 1'b0;
        w_done_r    <= 1'b0;
        AXI_awvalid <= 1'b0;
        AXI_wvalid  <= 1'b0;
        AXI_bready  <= 1'b0;
        AXI_arvalid <= 1'b0;
        AXI_rready  <= 1'b0;
        rsp_resp    <= 2'b11;
        rsp_rdata   <= '0;
        rsp_valid   <= 1'b1;
        state_r     <= DONE;
      end else if (busy_s && !leave_s) begin
        timer_r <= timer_r + 1'b1;
      end else begin
        timer_r <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi_4lite_master.sv
// Scoreboard bench for axi_4lite_master against a behavioural axi_4lite-like slave.
module tb_axi_4lite_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  AXI_awaddr, AXI_areadaddr;
  logic        AXI_awvalid, AXI_awready, AXI_wvalid, AXI_wready;
  logic [31:0] AXI_wdata, AXI_rdata;
  logic [3:0]  AXI_wstrb;
  logic [1:0]  AXI_bresp, AXI_rresp;
  logic        AXI_bvalid, AXI_bready, AXI_arvalid, AXI_arready, AXI_rvalid, AXI_rready;
  logic [2:0]  AXI_arprotect;

  axi_4lite_master #(.AXI_Dwidth(32), .AXI_Addrwidth(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .AXI_aclk(clk), .AXI_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AXI_awaddr(AXI_awaddr), .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
    .AXI_wdata(AXI_wdata), .AXI_wstrb(AXI_wstrb), .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
    .AXI_bresp(AXI_bresp), .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready),
    .AXI_areadaddr(AXI_areadaddr), .AXI_arprotect(AXI_arprotect),
    .AXI_arvalid(AXI_arvalid), .AXI_arready(AXI_arready),
    .AXI_rdata(AXI_rdata), .AXI_rresp(AXI_rresp), .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave (ready one cycle after valid, response one cycle after handshake)
  logic [31:0] mem [4];
  logic [3:0]  cap_awaddr, cap_wstrb;
  logic [31:0] cap_wdata;
  logic        have_aw, have_w;
  int          aw_wait, n_aw, n_w, n_b;
  int          aw_delay = 0;
  bit          no_resp = 1'b0, b_hold = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  wire        aw_hs     = AXI_awvalid & AXI_awready;
  wire        w_hs      = AXI_wvalid & AXI_wready;
  wire        have_aw_n = have_aw | aw_hs;
  wire        have_w_n  = have_w | w_hs;
  wire [3:0]  wa = aw_hs ? AXI_awaddr : cap_awaddr;
  wire [31:0] wd = w_hs ? AXI_wdata : cap_wdata;
  wire [3:0]  ws = w_hs ? AXI_wstrb : cap_wstrb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AXI_awready <= 1'b0; AXI_wready <= 1'b0; AXI_bvalid <= 1'b0; AXI_bresp <= 2'b00;
      AXI_arready <= 1'b0; AXI_rvalid <= 1'b0; AXI_rdata <= 32'h0; AXI_rresp <= 2'b00;
      have_aw <= 1'b0; have_w <= 1'b0; aw_wait <= 0;
      cap_awaddr <= 4'h0; cap_wdata <= 32'h0; cap_wstrb <= 4'h0;
      for (int i = 0; i < 4; i++) mem[i] <= 32'h0;
    end else begin
      AXI_awready <= AXI_awvalid && !AXI_awready && !have_aw && (aw_wait >= aw_delay) && !no_resp;
      aw_wait     <= (AXI_awvalid && !AXI_awready) ? aw_wait + 1 : 0;
      AXI_wready  <= AXI_wvalid && !AXI_wready && !have_w && !no_resp;
      if (aw_hs) begin cap_awaddr <= AXI_awaddr; n_aw <= n_aw + 1; end
      if (w_hs) begin cap_wdata <= AXI_wdata; cap_wstrb <= AXI_wstrb; n_w <= n_w + 1; end
      if (have_aw_n && have_w_n && !AXI_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (ws[b]) mem[wa[3:2]][8*b +: 8] <= wd[8*b +: 8];
        have_aw <= 1'b0; have_w <= 1'b0;
        if (!b_hold) begin AXI_bvalid <= 1'b1; AXI_bresp <= bresp_cfg; end
      end else begin
        have_aw <= have_aw_n; have_w <= have_w_n;
      end
      if (AXI_bvalid && AXI_bready) begin AXI_bvalid <= 1'b0; n_b <= n_b + 1; end
      AXI_arready <= AXI_arvalid && !AXI_arready && !AXI_rvalid && !no_resp;
      if (AXI_arvalid && AXI_arready) begin
        AXI_rvalid <= 1'b1; AXI_rdata <= mem[AXI_areadaddr[3:2]]; AXI_rresp <= rresp_cfg;
      end else if (AXI_rvalid && AXI_rready) begin
        AXI_rvalid <= 1'b0;
      end
    end
  end

  initial begin n_aw = 0; n_w = 0; n_b = 0; end

  // ---------------- monitor: pops the scoreboard on every response handshake
  initial begin
    exp_t e;
    bit   idle_chk;
    idle_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle_chk = 1'b0;
      end else begin
        if (idle_chk) begin
          chk("rsp_valid_after_handshake", {31'b0, rsp_valid}, 32'd0);
          chk("cmd_ready_after_handshake", {31'b0, cmd_ready}, 32'd1);
          idle_chk = 1'b0;
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rdata %h resp %0d expected no response", rsp_rdata, rsp_resp);
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, e.resp});
            if (e.lat >= 0) chk("rsp_latency", cyc - e.acc, e.lat);
          end
          idle_chk = 1'b1;
        end
      end
    end
  end

  // Accept edge closes cycle N; with the model slave rsp_valid appears in cycle N+4, i.e. 3 edges later.
  task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic [1:0] eresp, input int lat);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready %0d after %0d cycles expected 1", cmd_ready, n);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      e.rdata = er; e.resp = eresp; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: outstanding %0d expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  // ---------------- directed stimulus
  initial begin
    int aw0, w0, b0, n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_resp", {30'b0, rsp_resp}, 32'd0);
    chk("rst_valids_readies", {27'b0, AXI_awvalid, AXI_wvalid, AXI_bready, AXI_arvalid, AXI_rready}, 32'd0);
    chk("rst_addr_data", {AXI_awaddr, AXI_areadaddr, AXI_wstrb, AXI_arprotect, 17'b0}, 32'd0);
    chk("rst_wdata", AXI_wdata, 32'd0);

    issue(1'b1, 4'h0, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 3);
    drain();
    issue(1'b0, 4'h0, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 3);
    drain();
    issue(1'b1, 4'h4, 32'h12345678, 4'h3, 32'h0, 2'b00, 3);
    drain();
    issue(1'b0, 4'h4, 32'h0, 4'h0, 32'h00005678, 2'b00, 3);
    drain();

    // W accepted three cycles before AW; slave reports SLVERR
    aw_delay = 3; bresp_cfg = 2'b10;
    aw0 = n_aw; w0 = n_w; b0 = n_b;
    issue(1'b1, 4'h8, 32'hA5A5A5A5, 4'hF, 32'h0, 2'b10, -1);
    drain();
    chk("skew_aw_beats", n_aw - aw0, 32'd1);
    chk("skew_w_beats", n_w - w0, 32'd1);
    chk("skew_b_beats", n_b - b0, 32'd1);
    aw_delay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b01;
    issue(1'b0, 4'h8, 32'h0, 4'h0, 32'hA5A5A5A5, 2'b01, 3);
    drain();
    rresp_cfg = 2'b00;

    // Response held back by the consumer for five cycles
    issue(1'b1, 4'hC, 32'h0BADF00D, 4'hF, 32'h0, 2'b00, 3);
    drain();
    rsp_ready = 1'b0;
    issue(1'b0, 4'hC, 32'h0, 4'h0, 32'h0BADF00D, 2'b00, -1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h0BADF00D);
      chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Reset asserted while waiting for B
    b_hold = 1'b1;
    issue(1'b1, 4'h0, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00, -1);
    n = 0;
    while (!AXI_bready && n < 50) begin @(negedge clk); n++; end
    chk("reach_wr_resp", {31'b0, AXI_bready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valids_readies", {27'b0, AXI_awvalid, AXI_wvalid, AXI_bready, AXI_arvalid, AXI_rready}, 32'd0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    sb.delete();
    b_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    issue(1'b1, 4'h0, 32'h11223344, 4'h9, 32'h0, 2'b00, 3);
    drain();
    issue(1'b0, 4'h0, 32'h0, 4'h0, 32'h11000044, 2'b00, 3);
    drain();

`ifdef AXI_MASTER_TIMEOUT_EN
    // Silent slave: both kinds of transaction must abort with 2'b11
    no_resp = 1'b1;
    issue(1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b11, -1);
    drain();
    issue(1'b0, 4'h4, 32'h0, 4'h0, 32'h0, 2'b11, -1);
    drain();
    no_resp = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
